// File: rtl/wc_fifo_pkg.sv
// Shared helpers and reset constants for the wide-to-narrow sync FIFO.
package wc_fifo_pkg;

    localparam logic RST_EMPTY = 1'b1;
    localparam logic RST_FULL  = 1'b0;
    localparam logic RST_ERR   = 1'b0;

    // Ceiling log2 for parameter derivation; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = 32'(i + 1);
        end
        return r;
    endfunction

    // Bit offset of narrow slice idx within a wide word.
    function automatic int unsigned slice_off(input int unsigned idx,
                                              input int unsigned ratio,
                                              input int unsigned dw,
                                              input bit          msb_first);
        return msb_first ? (ratio - 1 - idx) * dw : idx * dw;
    endfunction

endpackage

// File: rtl/wc_fifo_ram.sv
// Simple dual-port RAM with synchronous write and a registered wide read port.
module wc_fifo_ram
    import wc_fifo_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          tb_rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read register only loads on an accepted read, so it holds between reads.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst)     rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/wc_sync_fifo.sv
// Single-clock FIFO taking WR_DW-wide words and returning RD_DW-wide slices.
// Define WC_FIFO_OUTPUT_REG_EN to add an output register (read latency 2).
module wc_sync_fifo
    import wc_fifo_pkg::*;
#(
    parameter int unsigned RD_DW            = 8,
    parameter int unsigned RATIO            = 4,
    parameter int unsigned WR_DW            = RD_DW * RATIO,
    parameter int unsigned WR_AW            = 8,
    parameter int unsigned RD_AW            = WR_AW + clog2(RATIO),
    parameter bit          MSB_FIRST        = 1'b1,
    parameter int unsigned ALMOST_FULL_NUM  = 127,
    parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
    input  logic             clk,
    input  logic             tb_rst,
    input  logic [WR_DW-1:0] wr_data,
    input  logic             wr_en,
    output logic             wr_full,
    output logic [WR_AW:0]   wr_water_level,
    output logic             almost_full,
    output logic             overflow,
    output logic [RD_DW-1:0] rd_data,
    input  logic             rd_en,
    output logic             rd_empty,
    output logic [RD_AW:0]   rd_water_level,
    output logic             almost_empty,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int unsigned LG = clog2(RATIO);
    localparam int unsigned SW = (LG == 0) ? 1 : LG;
    localparam int unsigned CW = RD_AW + 1;
    localparam int unsigned LW = WR_AW + 1;
    localparam int unsigned OW = (clog2(WR_DW) == 0) ? 1 : clog2(WR_DW);
    localparam logic [LW-1:0] DEPTH = LW'(1) << WR_AW;

    logic [LW-1:0]    wr_ptr, wr_ptr_nxt;
    logic [CW-1:0]    rd_ptr, rd_ptr_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [LW-1:0]    wr_lvl_nxt;
    logic             wr_acc_c, rd_acc_c;
    logic             ovf_nxt, udf_nxt;
    logic [SW-1:0]    slice_q;
    logic [WR_DW-1:0] ram_q;
    logic [OW-1:0]    off_c;
    logic [RD_DW-1:0] slice_c;

    // Accept decisions use the registered (pre-edge) flags only.
    always_comb begin
        wr_acc_c   = wr_en & ~wr_full;
        rd_acc_c   = rd_en & ~rd_empty;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        cnt_nxt    = cnt;
        if (wr_acc_c) wr_ptr_nxt = wr_ptr + LW'(1);
        if (rd_acc_c) rd_ptr_nxt = rd_ptr + CW'(1);
        case ({wr_acc_c, rd_acc_c})
            2'b10:   cnt_nxt = cnt + CW'(RATIO);
            2'b01:   cnt_nxt = cnt - CW'(1);
            2'b11:   cnt_nxt = cnt + CW'(RATIO - 1);
            default: cnt_nxt = cnt;
        endcase
        // A partially read wide slot still counts as occupied.
        wr_lvl_nxt = LW'((cnt_nxt + CW'(RATIO - 1)) >> LG);
        ovf_nxt    = (overflow  & ~clr_err) | (wr_en & wr_full);
        udf_nxt    = (underflow & ~clr_err) | (rd_en & rd_empty);
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            cnt            <= '0;
            slice_q        <= '0;
            wr_water_level <= '0;
            wr_full        <= RST_FULL;
            almost_full    <= RST_FULL;
            rd_empty       <= RST_EMPTY;
            almost_empty   <= RST_EMPTY;
            overflow       <= RST_ERR;
            underflow      <= RST_ERR;
        end else begin
            wr_ptr         <= wr_ptr_nxt;
            rd_ptr         <= rd_ptr_nxt;
            cnt            <= cnt_nxt;
            if (rd_acc_c) slice_q <= SW'(rd_ptr & CW'(RATIO - 1));
            wr_water_level <= wr_lvl_nxt;
            wr_full        <= (wr_lvl_nxt == DEPTH);
            almost_full    <= (32'(wr_lvl_nxt) >= ALMOST_FULL_NUM);
            rd_empty       <= (cnt_nxt == '0);
            almost_empty   <= (32'(cnt_nxt) <= ALMOST_EMPTY_NUM);
            overflow       <= ovf_nxt;
            underflow      <= udf_nxt;
        end
    end

    assign rd_water_level = cnt;

    wc_fifo_ram #(
        .DW (WR_DW),
        .AW (WR_AW)
    ) u_ram (
        .clk     (clk),
        .tb_rst  (tb_rst),
        .wr_en   (wr_acc_c),
        .wr_addr (wr_ptr[WR_AW-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_acc_c),
        .rd_addr (rd_ptr[RD_AW-1:LG]),
        .rd_data (ram_q)
    );

    // Slice mux driven by the slice index captured alongside the RAM read.
    always_comb begin
        off_c   = OW'(slice_off(32'(slice_q), RATIO, RD_DW, MSB_FIRST));
        slice_c = ram_q[off_c +: RD_DW];
    end

`ifdef WC_FIFO_OUTPUT_REG_EN
    logic             rd_vld_q;
    logic [RD_DW-1:0] rd_data_q;

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_vld_q <= rd_acc_c;
            if (rd_vld_q) rd_data_q <= slice_c;
        end
    end

    assign rd_data = rd_data_q;
`else
    assign rd_data = slice_c;
`endif

    logic unused_ptr_msb;
    assign unused_ptr_msb = &{1'b0, wr_ptr[WR_AW], rd_ptr[RD_AW]};

endmodule
